// File: rtl/ifu_pkg.sv
// Shared constants and state encoding for the instruction fetch unit.
package ifu_pkg;

  localparam int INST_WIDTH      = 32;
  localparam int INST_ADDR_WIDTH = 32;

  localparam logic [INST_WIDTH-1:0]      INST_NOP     = 32'h0000_0013;
  localparam logic [INST_ADDR_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    RST_WAIT = 2'd0,
    FETCH    = 2'd1,
    HOLD     = 2'd2
  } ifuState_e;

endpackage

// File: rtl/ifu_skid_buf.sv
// One-entry skid buffer holding a fetched instruction while decode is stalled.
module ifu_skid_buf
  import ifu_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_i,
  input  logic                       drain_i,
  input  logic                       flush_i,
  input  logic [INST_WIDTH-1:0]      data_i,
  input  logic [INST_ADDR_WIDTH-1:0] addr_i,
  output logic [INST_WIDTH-1:0]      data_o,
  output logic [INST_ADDR_WIDTH-1:0] addr_o,
  output logic                       valid_o
);

  logic [INST_WIDTH-1:0]      data_q;
  logic [INST_ADDR_WIDTH-1:0] addr_q;
  logic                       valid_q;

  // A flush from a redirect wins over a same-cycle load or drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= INST_NOP;
      addr_q  <= '0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      addr_q  <= addr_i;
      valid_q <= 1'b1;
    end else if (drain_i) begin
      valid_q <= 1'b0;
    end
  end

  assign data_o  = data_q;
  assign addr_o  = addr_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: pc sequencing, fetch FSM and decode-facing output registers.
// Define IFU_MISALIGN_CHECK_EN to flag redirects whose target has nonzero low bits.
module ifu
  import ifu_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req_o,
  output logic [INST_ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                       imem_ack_i,
  input  logic [INST_WIDTH-1:0]      imem_rdata_i,
  input  logic                       jump_en_i,
  input  logic [INST_ADDR_WIDTH-1:0] jump_addr_i,
  input  logic                       hold_i,
  output logic [INST_WIDTH-1:0]      inst_o,
  output logic [INST_ADDR_WIDTH-1:0] inst_addr_o,
  output logic                       inst_valid_o,
  output logic                       misalign_o
);

  ifuState_e                  state_q, state_d;
  logic [INST_ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [INST_WIDTH-1:0]      inst_q, inst_d;
  logic [INST_ADDR_WIDTH-1:0] instAddr_q, instAddr_d;
  logic                       instValid_q, instValid_d;

  logic                       skidLoad, skidDrain, skidFlush;
  logic [INST_WIDTH-1:0]      skidData;
  logic [INST_ADDR_WIDTH-1:0] skidAddr;
  logic                       skidValid;
  logic [INST_ADDR_WIDTH-1:0] jumpTarget;

  assign jumpTarget = jump_addr_i & ~32'h3;

  ifu_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (skidLoad),
    .drain_i (skidDrain),
    .flush_i (skidFlush),
    .data_i  (imem_rdata_i),
    .addr_i  (pc_q),
    .data_o  (skidData),
    .addr_o  (skidAddr),
    .valid_o (skidValid)
  );

  // Redirects beat stalls in every state except the single post-reset wait cycle.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    instAddr_d  = instAddr_q;
    instValid_d = instValid_q;
    skidLoad    = 1'b0;
    skidDrain   = 1'b0;
    skidFlush   = 1'b0;
    if (state_q != RST_WAIT && jump_en_i) begin
      pc_d        = jumpTarget;
      skidFlush   = 1'b1;
      inst_d      = INST_NOP;
      instValid_d = 1'b0;
      state_d     = FETCH;
    end else begin
      case (state_q)
        RST_WAIT: state_d = FETCH;
        FETCH: begin
          if (imem_ack_i && !hold_i) begin
            inst_d      = imem_rdata_i;
            instAddr_d  = pc_q;
            instValid_d = 1'b1;
            pc_d        = pc_q + 32'd4;
          end else if (imem_ack_i && hold_i) begin
            skidLoad = 1'b1;
            state_d  = HOLD;
          end else if (!hold_i) begin
            inst_d      = INST_NOP;
            instValid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!hold_i) begin
            inst_d      = skidData;
            instAddr_d  = skidAddr;
            instValid_d = skidValid;
            skidDrain   = 1'b1;
            pc_d        = pc_q + 32'd4;
            state_d     = FETCH;
          end
        end
        default: state_d = RST_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RST_WAIT;
      pc_q        <= RESET_VECTOR;
      inst_q      <= INST_NOP;
      instAddr_q  <= '0;
      instValid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      instAddr_q  <= instAddr_d;
      instValid_q <= instValid_d;
    end
  end

`ifdef IFU_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  // Pulses for exactly one cycle after a redirect to a non-word-aligned target.
  always_comb begin
    misalign_d = 1'b0;
    if (state_q != RST_WAIT && jump_en_i) misalign_d = |jump_addr_i[1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end

  assign misalign_o = misalign_q;
`else
  assign misalign_o = 1'b0;
`endif

  assign imem_req_o   = (state_q == FETCH);
  assign imem_addr_o  = pc_q;
  assign inst_o       = inst_q;
  assign inst_addr_o  = instAddr_q;
  assign inst_valid_o = instValid_q;

endmodule

// File: tb/tb_ifu.sv
// Scoreboard bench for ifu: a queue-based reference model predicts outputs after each edge,
// and an independent monitor compares them against the DUT.
module tb_ifu;
  import ifu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck = 1'b0;
  logic [31:0] imemRdata = '0;
  logic        jumpEn = 1'b0;
  logic [31:0] jumpAddr = '0;
  logic        hold = 1'b0;
  logic [31:0] inst;
  logic [31:0] instAddr;
  logic        instValid;
  logic        misalign;

  always #5 clk = ~clk;

  ifu dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req_o   (imemReq),
    .imem_addr_o  (imemAddr),
    .imem_ack_i   (imemAck),
    .imem_rdata_i (imemRdata),
    .jump_en_i    (jumpEn),
    .jump_addr_i  (jumpAddr),
    .hold_i       (hold),
    .inst_o       (inst),
    .inst_addr_o  (instAddr),
    .inst_valid_o (instValid),
    .misalign_o   (misalign)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] instAddr;
    logic        instValid;
    logic        misalign;
    logic        imemReq;
    logic [31:0] imemAddr;
  } expect_t;

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
  } entry_t;

  expect_t expQ[$];
  entry_t  pending[$];

  logic [31:0] mPc = '0;
  logic [31:0] mInst = 32'h13;
  logic [31:0] mInstAddr = '0;
  logic        mValid = 1'b0;
  logic        mMis = 1'b0;
  bit          mWaiting = 1'b1;

  int testsRun = 0;
  int testsFailed = 0;

  // The model stalls exactly when a captured instruction is pending downstream.
  task automatic applyStimulus(input bit r, input bit a, input logic [31:0] d,
                               input bit j, input logic [31:0] ja, input bit h);
    expect_t e;
    entry_t  ent;
    @(negedge clk);
    rst = r; imemAck = a; imemRdata = d; jumpEn = j; jumpAddr = ja; hold = h;
    mMis = 1'b0;
    if (r) begin
      mPc = 32'h0; mWaiting = 1'b1; pending.delete();
      mInst = 32'h13; mInstAddr = 32'h0; mValid = 1'b0;
    end else if (mWaiting) begin
      mWaiting = 1'b0;
    end else if (j) begin
      mPc = {ja[31:2], 2'b00};
      pending.delete();
      mInst = 32'h13; mValid = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
      mMis = (ja[1:0] != 2'b00);
`endif
    end else if (pending.size() != 0) begin
      if (!h) begin
        ent = pending.pop_front();
        mInst = ent.data; mInstAddr = ent.addr; mValid = 1'b1;
        mPc = mPc + 32'd4;
      end
    end else if (a && !h) begin
      mInst = d; mInstAddr = mPc; mValid = 1'b1; mPc = mPc + 32'd4;
    end else if (a && h) begin
      ent.data = d; ent.addr = mPc;
      pending.push_back(ent);
    end else if (!h) begin
      mInst = 32'h13; mValid = 1'b0;
    end
    e.inst = mInst; e.instAddr = mInstAddr; e.instValid = mValid; e.misalign = mMis;
    e.imemReq = !mWaiting && (pending.size() == 0);
    e.imemAddr = mPc;
    expQ.push_back(e);
  endtask

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input expect_t e);
    checkField("inst_o", inst, e.inst);
    checkField("inst_addr_o", instAddr, e.instAddr);
    checkField("inst_valid_o", {31'b0, instValid}, {31'b0, e.instValid});
    checkField("misalign_o", {31'b0, misalign}, {31'b0, e.misalign});
    checkField("imem_req_o", {31'b0, imemReq}, {31'b0, e.imemReq});
    checkField("imem_addr_o", imemAddr, e.imemAddr);
  endtask

  // Monitor: every edge the DUT presents a new output set, compared against the oldest prediction.
  initial begin
    expect_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    logic [31:0] ja;
    // Reset, then continuous fetch of one instruction word.
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 0);
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 0);
    applyStimulus(0, 1, 32'h00A00093, 0, 32'h0, 0);
    for (int i = 0; i < 2; i++) applyStimulus(0, 1, 32'h00A00093, 0, 32'h0, 0);
    // Stall on the fetch at 0x8 for three cycles, then release.
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 32'h11111111, 0, 32'h0, 1);
    applyStimulus(0, 1, 32'h22222222, 0, 32'h0, 0);
    applyStimulus(0, 1, 32'h33333333, 0, 32'h0, 0);
    // Redirect while stalled with a live ack.
    applyStimulus(0, 1, 32'h44444444, 0, 32'h0, 1);
    applyStimulus(0, 1, 32'h55555555, 1, 32'h100, 1);
    applyStimulus(0, 1, 32'h66666666, 0, 32'h0, 0);
    // pc wraparound at the top of the address space.
    applyStimulus(0, 0, 32'h0, 1, 32'hFFFFFFFC, 0);
    applyStimulus(0, 1, 32'h77777777, 0, 32'h0, 0);
    applyStimulus(0, 1, 32'h88888888, 0, 32'h0, 0);
    // Misaligned redirect target.
    applyStimulus(0, 0, 32'h0, 1, 32'h102, 0);
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 0);
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 0);
    // Reset while stalled with the buffer full, and a jump ignored in the wait cycle.
    applyStimulus(0, 1, 32'h99999999, 0, 32'h0, 1);
    applyStimulus(1, 1, 32'hAAAAAAAA, 1, 32'h200, 1);
    applyStimulus(0, 1, 32'hBBBBBBBB, 1, 32'h300, 0);
    applyStimulus(0, 1, 32'hCCCCCCCC, 0, 32'h0, 0);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      ja = $urandom;
      if ($urandom_range(0, 3) == 0) ja = 32'hFFFFFFF0 | (ja & 32'hF);
      applyStimulus($urandom_range(0, 99) < 2, $urandom_range(0, 9) < 7, $urandom,
                    $urandom_range(0, 9) == 0, ja, $urandom_range(0, 9) < 3);
    end
    @(posedge clk);
    #2;
    testsRun++;
    if (expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL drain: got %0d leftover predictions expected 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-003 SHALL have port imem_req_o, output, 1: instruction memory request.
REQ-004 SHALL have port imem_addr_o, output, INST_ADDR_WIDTH (32): fetch address, equal to current pc.
REQ-005 SHALL have port imem_ack_i, input, 1: memory returns imem_rdata_i for imem_addr_o in the same cycle.
REQ-006 SHALL have port imem_rdata_i, input, INST_WIDTH (32): fetched instruction.
REQ-007 SHALL have port jump_en_i, input, 1: redirect request from executrol.
REQ-008 SHALL have port jump_addr_i, input, 32: redirect target.
REQ-009 SHALL have port hold_i, input, 1: downstream stall; freezes the decode-facing outputs.
REQ-010 SHALL have port inst_o, output, 32: instruction to id.
REQ-011 SHALL have port inst_addr_o, output, 32: address of inst_o.
REQ-012 SHALL have port inst_valid_o, output, 1: inst_o holds a real fetched instruction.
REQ-013 SHALL have port misalign_o, output, 1: misaligned redirect flag; present in both macro configurations.

Function
REQ-014 SHALL implement FSM states RST_WAIT, FETCH, HOLD; RST_WAIT lasts exactly one cycle after reset, then moves to FETCH.
REQ-015 SHALL drive imem_req_o=1 only in FETCH, with imem_addr_o=pc; request held until ack.
REQ-016 FETCH, ack=1, hold_i=0: SHALL load inst_o<=imem_rdata_i, inst_addr_o<=pc, inst_valid_o<=1, pc<=pc+4 at the next edge; one instruction per cycle under continuous ack.
REQ-017 FETCH, ack=0, hold_i=0: SHALL set inst_o<=NOP (0x00000013), inst_valid_o<=0; pc unchanged.
REQ-018 FETCH, ack=1, hold_i=1: SHALL capture rdata and pc into the one-entry skid buffer, leave outputs frozen, and move to HOLD.
REQ-019 HOLD: imem_req_o=0; while hold_i=1, outputs and buffer SHALL be frozen; on hold_i=0 the buffer SHALL move to the outputs (valid=1), pc<=pc+4, state->FETCH.
REQ-020 FETCH, ack=0, hold_i=1: outputs SHALL be frozen and state SHALL remain FETCH.
REQ-021 jump_en_i=1 SHALL take priority in any state other than RST_WAIT, even when hold_i=1:
  - pc<={jump_addr_i[31:2],2'b00}
  - skid buffer and same-cycle ack data discarded
  - inst_o<=NOP, inst_valid_o<=0
  - state->FETCH
REQ-022 pc arithmetic SHALL be modulo 2^32: 0xFFFFFFFC+4 -> 0x00000000.
REQ-023 A jump_en_i asserted in RST_WAIT SHALL be ignored.

Reset
REQ-024 On rst=1 at an edge SHALL set:
  - pc=RESET_VECTOR (0x00000000)
  - state=RST_WAIT
  - inst_o=NOP, inst_addr_o=0, inst_valid_o=0, misalign_o=0
  - skid buffer cleared; imem_req_o=0 during the following cycle
REQ-025 Reset mid-operation (including in HOLD or on a redirect cycle) SHALL override every other input.

Configuration
REQ-026 Macro IFU_MISALIGN_CHECK_EN defined: a redirect with jump_addr_i[1:0]!=0 SHALL set misalign_o=1 for exactly the next cycle; the redirect still proceeds per REQ-021.
REQ-027 Macro undefined: misalign_o SHALL be tied 0; low target bits are cleared silently.

Structure
REQ-028 defines.v SHALL hold INST_WIDTH, INST_ADDR_WIDTH, INST_NOP, RESET_VECTOR and the IFU state encodings.
REQ-029 The skid buffer SHALL be the sub-module ifu_skid_buf (load, drain and flush inputs; data, addr and valid outputs); pc logic and the FSM stay in ifu.

Verification
REQ-030 Reset, then ack tied 1, rdata=0x00A00093: inst_addr_o sequence 0x0,0x4,0x8 on consecutive cycles, each inst_valid_o=1.
REQ-031 Hold during ack at pc=0x8 for 3 cycles: outputs frozen at 0x4; imem_req_o=0 in HOLD; on release inst_addr_o=0x8, next fetch 0xC.
REQ-032 jump_en_i with jump_addr_i=0x100 while hold_i=1 and ack=1: next cycle inst_o=0x00000013, valid=0, imem_addr_o=0x100.
REQ-033 pc=0xFFFFFFFC, ack=1: next imem_addr_o=0x00000000.
REQ-034 jump_addr_i=0x102: with the macro, misalign_o=1 for one cycle and pc=0x100; without it, misalign_o stays 0 and pc=0x100.
REQ-035 rst in HOLD with buffer full: next cycle inst_valid_o=0, imem_req_o=0; the cycle after, imem_addr_o=0x0.
